// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with one outstanding request and a 1-entry skid buffer.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_gnt,
    input  logic        im_rvalid,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_PC,
    output logic [31:0] F_instruction,
    output logic        F_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_drop_cnt
`endif
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] next_pc_q, next_pc_d, req_pc_q, req_pc_d;
    logic [31:0] f_pc_q, f_pc_d, f_instr_q, f_instr_d;
    logic        f_valid_q, f_valid_d;
    logic [31:0] skid_pc_q, skid_pc_d, skid_instr_q, skid_instr_d;
    logic        skid_valid_q, skid_valid_d;
    logic        grant, rsp_ok, rsp_drop, consume;

    assign im_req        = (state_q == REQ) && !skid_valid_q;
    assign im_addr       = next_pc_q;
    assign grant         = im_req && im_gnt;
    assign rsp_ok        = (state_q == WAIT) && im_rvalid && !redirect;
    assign rsp_drop      = im_rvalid && (((state_q == WAIT) && redirect) || (state_q == DROP));
    assign consume       = f_valid_q && !stall;
    assign F_PC          = f_pc_q;
    assign F_instruction = f_instr_q;
    assign F_valid       = f_valid_q;

    always_comb begin
        state_d      = state_q;
        f_pc_d       = f_pc_q;
        f_instr_d    = f_instr_q;
        f_valid_d    = f_valid_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        skid_valid_d = skid_valid_q;
        req_pc_d     = grant ? next_pc_q : req_pc_q;
        next_pc_d    = redirect ? (redirect_pc & 32'hFFFF_FFFC) : grant ? next_pc_q + 32'd4 : next_pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = grant ? (redirect ? DROP : WAIT) : REQ;
            WAIT: state_d = im_rvalid ? REQ : (redirect ? DROP : WAIT);
            DROP: state_d = im_rvalid ? REQ : DROP;
        endcase
        // A response landing while F_* is held goes to the skid buffer; no new request is issued until it drains.
        if (redirect) begin
            f_valid_d    = 1'b0;
            f_instr_d    = 32'h0;
            skid_valid_d = 1'b0;
        end else if (consume) begin
            if (skid_valid_q) begin
                f_pc_d       = skid_pc_q;
                f_instr_d    = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (rsp_ok) begin
                f_pc_d    = req_pc_q;
                f_instr_d = im_rdata;
            end else begin
                f_valid_d = 1'b0;
                f_instr_d = 32'h0;
            end
        end else if (!f_valid_q) begin
            if (rsp_ok) begin
                f_pc_d    = req_pc_q;
                f_instr_d = im_rdata;
                f_valid_d = 1'b1;
            end
        end else if (rsp_ok) begin
            skid_pc_d    = req_pc_q;
            skid_instr_d = im_rdata;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            next_pc_q    <= RESET_PC;
            req_pc_q     <= 32'h0;
            f_pc_q       <= 32'h0;
            f_instr_q    <= 32'h0;
            f_valid_q    <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            skid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_pc_q    <= next_pc_d;
            req_pc_q     <= req_pc_d;
            f_pc_q       <= f_pc_d;
            f_instr_q    <= f_instr_d;
            f_valid_q    <= f_valid_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_valid_q <= skid_valid_d;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_drop_cnt  <= 32'h0;
        end else begin
            perf_fetch_cnt <= perf_fetch_cnt + {31'h0, rsp_ok};
            perf_drop_cnt  <= perf_drop_cnt + {31'h0, rsp_drop};
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
    logic        im_gnt = 1'b1, im_rvalid = 1'b0;
    logic [31:0] redirect_pc = 32'h0, im_rdata = 32'h0;
    logic        im_req, F_valid;
    logic [31:0] im_addr, F_PC, F_instruction;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_drop_cnt;
`endif
    int          n_chk = 0, n_fail = 0, pcnt = 0, lat = 0, pres = 0;
    logic        stray = 1'b0, fired = 1'b0;
    logic [31:0] fire_addr = 32'h0, mem_addr = 32'h0, exp_pc = 32'h0, last_pc = 32'h0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt), .im_rvalid(im_rvalid), .im_rdata(im_rdata),
        .F_PC(F_PC), .F_instruction(F_instruction), .F_valid(F_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    function automatic logic [31:0] enc(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive memory for the coming edge, predict grants, then check F_* at the next negedge.
    task automatic cyc();
        logic was_redir, can_load;
        im_rvalid = (pcnt == 1) || stray;
        im_rdata  = (pcnt == 1) ? enc(mem_addr) : 32'hDEAD_BEEF;
        if (pcnt > 0) pcnt--;
        stray = 1'b0;
        fired = im_req && im_gnt;
        if (fired) begin
            fire_addr = im_addr;
            mem_addr  = im_addr;
            pcnt      = lat + 1;
            chk("im_addr", im_addr, exp_pc);
            if (!redirect) q.push_back(exp_pc);
            exp_pc += 32'd4;
        end
        if (redirect) begin
            q.delete();
            exp_pc = redirect_pc & 32'hFFFF_FFFC;
        end
        was_redir = redirect;
        can_load  = !F_valid || !stall;
        @(negedge clk);
        redirect = 1'b0;
        if (was_redir) chk("redir_valid", F_valid, 0);
        else if (can_load && F_valid) begin
            pres++;
            chk("queue_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
                last_pc = q.pop_front();
                chk("F_PC", F_PC, last_pc);
                chk("F_instruction", F_instruction, enc(last_pc));
            end
        end
        if (!F_valid) chk("instr_zero", F_instruction, 0);
    endtask

    task automatic wait_fire();
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) cyc();
        chk("wait_fire", fired, 1);
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20 && !F_valid; i++) cyc();
        chk("wait_valid", F_valid, 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_im_req"}, im_req, 0);
        chk({tag, "_F_valid"}, F_valid, 0);
        chk({tag, "_F_PC"}, F_PC, 0);
        chk({tag, "_F_instr"}, F_instruction, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; stall = 1'b0; im_rvalid = 1'b0;
        q.delete(); pcnt = 0; stray = 1'b0; exp_pc = 32'h0; lat = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        pres = 0;
        repeat (20) cyc();
        chk("throughput", pres, 9);

        wait_valid();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", F_valid, 1);
            chk("stall_pc", F_PC, last_pc);
            chk("stall_instr", F_instruction, enc(last_pc));
        end
        chk("stall_no_req", im_req, 0);
        stall = 1'b0;
        fired = 1'b0;
        cyc();
        chk("skid_drain_pc", F_PC, last_pc);
        chk("skid_drain_valid", F_valid, 1);
        repeat (8) cyc();

        do_reset();
        lat = 2;
        wait_fire();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cyc();
        wait_fire();
        chk("redir_wait_target", fire_addr, 32'h0000_0100);
`ifdef FETCH_PERF_EN
        chk("perf_drop", perf_drop_cnt, 1);
        chk("perf_fetch", perf_fetch_cnt, 0);
`endif
        lat = 0;
        repeat (6) cyc();

        do_reset();
        wait_fire();
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        cyc();
        wait_fire();
        chk("redir_rvalid_target", fire_addr, 32'h0000_0200);
        repeat (4) cyc();

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc();
        wait_fire();
        chk("wrap_first", fire_addr, 32'hFFFF_FFFC);
        wait_fire();
        chk("wrap_second", fire_addr, 32'h0000_0000);
        repeat (4) cyc();

        lat = 1;
        wait_fire();
        rst = 1'b1;
        #2;
        chk_reset("async_rst");
        rst = 1'b0;
        q.delete(); exp_pc = 32'h0; pcnt = 0; lat = 0; stray = 1'b1;
        cyc();
        chk("stray_valid", F_valid, 0);
        chk("stray_pc", F_PC, 0);
        wait_fire();
        chk("post_rst_addr", fire_addr, 32'h0000_0000);
        repeat (6) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
